sram_bus_arbiter: RTL
=====================

// Module: sram_bus_arbiter
// PURPOSE
//   Shares one SRAM-like memory port (req/addr_ok/data_ok) between the IF-stage instruction
//   requester and the MEM-stage data requester.
//   Fixed priority, data over inst; a requester that has started a request keeps the grant.
//   An in-order ID FIFO routes each data_ok/rdata back to the requester that issued it.
//   Sits between the pipeline stages and the bus bridge.
// PARAMETERS
//   OUTSTANDING  2  max accepted-but-unanswered bus transactions (ID FIFO depth, power of 2, >=2)
// PORTS
//   clk             in   1   clock
//   rst             in   1   synchronous active-high reset
//   inst_req        in   1   IF request valid
//   inst_wr         in   1   IF write (always 0 in practice)
//   inst_size       in   2   IF size: 0=byte, 1=half, 2=word
//   inst_addr       in   32  IF address
//   inst_wstrb      in   4   IF byte strobes
//   inst_wdata      in   32  IF write data
//   inst_addr_ok    out  1   IF request accepted
//   inst_data_ok    out  1   IF response valid
//   inst_rdata      out  32  IF read data
//   data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
//                   in   1/1/2/32/4/32   MEM requester, same meaning as inst_*
//   data_addr_ok    out  1   MEM request accepted
//   data_data_ok    out  1   MEM response valid
//   data_rdata      out  32  MEM read data
//   bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata
//                   out  1/1/2/32/4/32   shared port request
//   bus_addr_ok     in   1   shared port accepts request this cycle
//   bus_data_ok     in   1   shared port returns the oldest response
//   bus_rdata       in   32  shared port read data
//   proto_err       out  1   sticky: bus_data_ok arrived with ID FIFO empty
// BEHAVIOUR
//   - Reset: lock_valid=0, FIFO empty (count=0, rd/wr ptr=0), proto_err=0.
//     All outputs are 0 in the reset cycle and the cycle after.
//   - Selection (combinational):
//       if lock_valid:          sel = lock_id
//       else if data_req:       sel = DATA
//       else if inst_req:       sel = INST
//       else:                   no selection
//   - fifo_full = (count == OUTSTANDING).
//   - bus_req = selected req & ~fifo_full. bus_wr/size/addr/wstrb/wdata are muxed from sel.
//     When bus_req=0 they are 0.
//   - Handshake hs = bus_req & bus_addr_ok. It drives the addr_ok of sel only (1 cycle, same
//     cycle as hs). The other requester's addr_ok is 0. Zero-latency pass-through.
//   - Lock: if bus_req=1 and ~bus_addr_ok, set lock_valid=1, lock_id=sel at the clock edge.
//     Clear on the hs edge. While locked, the other requester cannot win even at higher priority.
//     This is required because SRAM-like masters must hold a request until addr_ok.
//   - ID FIFO: hs pushes sel. bus_data_ok pops the head.
//       - Head routes data_ok and rdata to that requester in the same cycle.
//       - Non-head rdata = 0.
//       - Write responses are routed the same way.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//     When full, no push is possible, since bus_req is gated even if a pop occurs that cycle.
//   - Pointers wrap modulo OUTSTANDING. count is $clog2(OUTSTANDING)+1 bits.
//   - bus_data_ok with count==0: no pop, no data_ok to either requester, proto_err<=1 until rst.
//   - The arbiter has no flush input. Stages discard cancelled responses themselves, so every
//     accepted transaction still gets its response routed.
//   - rst mid-transaction: FIFO and lock cleared immediately. The bus side is reset in the
//     same cycle by the same rst.
// TESTING
//   1. data_req=1 and inst_req=1 in the same cycle, bus_addr_ok=1.
//      -> data_addr_ok=1, inst_addr_ok=0, bus_addr=data_addr.
//      Next cycle inst is granted.
//   2. inst_req=1, bus_addr_ok=0 for 3 cycles. data_req rises in cycle 2.
//      -> bus_addr stays inst_addr until addr_ok. Only then is data granted (lock holds).
//   3. Issue inst read (addr 0x1C000000), then data read (addr 0x00001000).
//      Bus returns data_ok with rdata 0xAAAA then 0xBBBB.
//      -> inst_rdata=0xAAAA, data_rdata=0xBBBB, each with a single data_ok pulse.
//   4. OUTSTANDING=2, two accepted with no data_ok, third request pending.
//      -> bus_req=0 and addr_ok=0. After one bus_data_ok, bus_req=1 next cycle.
//   5. Full FIFO: data_ok pop and a pending request in the same cycle.
//      -> no push that cycle, count 2->1. Then the push brings count back to 2.
//   6. bus_data_ok=1 with FIFO empty.
//      -> both data_ok=0, proto_err=1 and held. rst clears proto_err and count.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Shares one SRAM-like memory port between the IF-stage (inst)
//            and MEM-stage (data) requesters. Fixed priority, data over
//            inst. A requester whose request is on the bus but not yet
//            accepted keeps the grant. An in-order ID FIFO routes every
//            response back to the requester that issued it.
// Ports    : clk, rst                     clock, sync active-high reset
//            inst_* / data_*              requester request + response side
//            bus_*                        shared SRAM-like port
//            proto_err                    sticky: response with no ID queued
// Revision : 1.0  initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        proto_err
);

    localparam int                 c_PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic               c_ID_INST  = 1'b0;
    localparam logic               c_ID_DATA  = 1'b1;
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(OUTSTANDING);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic               r_rst_hold;
    logic               r_lock_valid;
    logic               r_lock_id;
    logic               r_fifo_id [OUTSTANDING];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_proto_err;

    logic w_active;
    logic w_sel_valid;
    logic w_sel_id;
    logic w_sel_req;
    logic w_full;
    logic w_bus_req;
    logic w_hs;
    logic w_pop;
    logic w_head;

    // Outputs stay quiet during reset and for one cycle after it.
    assign w_active = ~rst & ~r_rst_hold;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = c_ID_INST;
        if (r_lock_valid) begin
            w_sel_valid = 1'b1;
            w_sel_id    = r_lock_id;
        end else if (data_req) begin
            w_sel_valid = 1'b1;
            w_sel_id    = c_ID_DATA;
        end else if (inst_req) begin
            w_sel_valid = 1'b1;
            w_sel_id    = c_ID_INST;
        end
    end

    assign w_sel_req = (w_sel_id == c_ID_DATA) ? data_req : inst_req;
    assign w_full    = (r_count == c_CNT_FULL);
    // Full gating also blocks a push in a cycle that pops, keeping the
    // FIFO from needing a same-cycle bypass.
    assign w_bus_req = w_active & w_sel_valid & w_sel_req & ~w_full;
    assign w_hs      = w_bus_req & bus_addr_ok;
    assign w_head    = r_fifo_id[r_rd_ptr];
    assign w_pop     = w_active & bus_data_ok & (r_count != '0);

    assign bus_req   = w_bus_req;
    assign bus_wr    = w_bus_req & (w_sel_id ? data_wr : inst_wr);
    assign bus_size  = w_bus_req ? (w_sel_id ? data_size  : inst_size)  : 2'd0;
    assign bus_addr  = w_bus_req ? (w_sel_id ? data_addr  : inst_addr)  : 32'd0;
    assign bus_wstrb = w_bus_req ? (w_sel_id ? data_wstrb : inst_wstrb) : 4'd0;
    assign bus_wdata = w_bus_req ? (w_sel_id ? data_wdata : inst_wdata) : 32'd0;

    assign inst_addr_ok = w_hs & (w_sel_id == c_ID_INST);
    assign data_addr_ok = w_hs & (w_sel_id == c_ID_DATA);

    assign inst_data_ok = w_pop & (w_head == c_ID_INST);
    assign data_data_ok = w_pop & (w_head == c_ID_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;

    assign proto_err = r_proto_err & w_active;

    always_ff @(posedge clk) begin
        r_rst_hold <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_valid <= 1'b0;
            r_lock_id    <= c_ID_INST;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            // A presented but unaccepted request pins the grant until
            // addr_ok, since the master may not withdraw it.
            if (w_bus_req & ~bus_addr_ok) begin
                r_lock_valid <= 1'b1;
                r_lock_id    <= w_sel_id;
            end else if (w_hs) begin
                r_lock_valid <= 1'b0;
            end

            if (w_hs) begin
                r_fifo_id[r_wr_ptr] <= w_sel_id;
                r_wr_ptr            <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_active & bus_data_ok & (r_count == '0)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
